morse_tx: RTL and testbench
===========================

Name: morse_tx

Overview:
Morse transmitter, the output-side counterpart of the two-button dot/dash entry block. It accepts one letter of up to 4 symbols, encoded MSB-first with 0=dot and 1=dash, and drives an LED with standard Morse timing. The LED sees 1-unit dots, 3-unit dashes, 1-unit intra-letter gaps and a 3-unit trailing letter gap. Upstream logic (code capture or a message ROM) feeds it through a valid/ready handshake.

Parameters:
UNIT_CYCLES, 6750000, clk cycles per Morse time unit (250 ms at 27 MHz); must be >= 2.
DASH_UNITS, 3, length of a dash mark in units.
LGAP_UNITS, 3, trailing letter-gap length in units.
CNT_W, 32, width of the cycle counter; must hold UNIT_CYCLES-1.

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  synchronous, active-high reset
code  in  4  symbols; code[3] is sent first; 0=dot, 1=dash
len  in  3  number of symbols to send, taken from the top of code (valid 1..4)
valid_in  in  1  letter offered
ready  out  1  high when idle and able to accept a letter
led  out  1  Morse output, 1=mark
busy  out  1  high from acceptance until done
done  out  1  one-cycle pulse when the trailing letter gap completes

Behaviour:
- Reset (synchronous, active-high; rst sampled on posedge clk): led=0, busy=0, done=0, ready=1, state=IDLE, all counters 0. Reset mid-letter aborts the letter with no done pulse.
- Accept: on a posedge with valid_in&&ready, latch code and len. The latched len is clamped to 4 if it exceeds 4.
- ready=0 while busy. valid_in while busy is ignored and has no side effects.
- len==0: no mark is sent. FSM goes to DONE. done pulses on the cycle after acceptance, and ready returns the cycle after that.
- States and transitions:
  - IDLE → MARK on accept.
  - MARK: led=1 for 1×UNIT_CYCLES (dot) or DASH_UNITS×UNIT_CYCLES (dash).
  - MARK → GAP if symbols remain; MARK → LGAP after the last symbol.
  - GAP: led=0 for exactly UNIT_CYCLES, then → MARK with the next symbol.
  - LGAP: led=0 for LGAP_UNITS×UNIT_CYCLES, then → DONE.
  - DONE: done=1 for one cycle, busy=0, then → IDLE.
- Latency: led rises on the cycle after acceptance. Every led high or low interval is an exact multiple of UNIT_CYCLES, with no off-by-one.
- Symbol select: a shift register is loaded with code and shifts left after each mark. The current symbol is sr[3]. A symbol counter counts down from len.
- Timing counters:
  - The cycle counter runs 0..UNIT_CYCLES-1, then wraps and emits a unit tick.
  - The unit counter counts ticks against the target duration of the current state.
  - Both counters clear on every state change, so there is no carry-over between phases.
- Letter length in units:
  - Total = Σmarks + (len-1) + LGAP_UNITS.
  - Example: code=0110, len=4 gives 8 + 3 + 3 = 14 units, and done fires at cycle 14×UNIT_CYCLES+1 after acceptance.
- Back-to-back: with valid_in held high, the next letter is accepted the cycle after done, when ready is high again. The LGAP provides the inter-letter spacing.
- Arithmetic: the counters are unsigned and never overflow within the parameter constraints.

Decomposition:
- Package morse_pkg holds:
  - symbol constants SYM_DOT=1'b0, SYM_DASH=1'b1;
  - default unit constants DOT_UNITS=1, DASH_UNITS=3, SGAP_UNITS=1, LGAP_UNITS=3;
  - the state enum {IDLE, MARK, GAP, LGAP, DONE}.
- The receiver block shares this package.
- One sub-module: morse_unit_tick, a prescaler with inputs clk, rst, clr and output tick. tick is high for one cycle every UNIT_CYCLES cycles, and clr restarts the count.

Test Plan:
All tests use UNIT_CYCLES=4.
1. Reset: hold rst 3 cycles → led=0, busy=0, done=0, ready=1. Release rst → outputs stay put with no valid_in.
2. Single dot (code=0000, len=1) → led high for cycles 1..4 after accept, low for 12 cycles, done pulse at cycle 17, ready=1 at cycle 18.
3. Letter "Q" (code=1101, len=4) → led pattern in units: 3 on, 1 off, 3 on, 1 off, 1 on, 1 off, 3 on, 3 off, with done at cycle 4×16+1=65. A valid_in pulse mid-letter is ignored.
4. len=0 and len=7 → len=0 gives no led activity and done 1 cycle after accept. len=7 behaves identically to len=4.
5. Reset mid-dash (rst asserted at cycle 6 of code=1000, len=1) → led=0 on the next cycle, no done pulse, ready=1. A new letter is then accepted normally.
6. Back-to-back: valid_in held high with "E" then "T" → second accept on the cycle after the first done. The gap between the E mark's falling edge and the T mark's rising edge is exactly 3 units + 2 cycles (the DONE and accept cycles).

Source files
------------

// File: rtl/morse_pkg.sv
// morse_pkg
// Shared definitions for the Morse transmitter and its companion
// two-button receiver: symbol encodings, default unit lengths of
// each Morse element, the transmitter state type and a helper that
// clamps an incoming symbol count to the 4-symbol letter format.
// No ports (package only).

package morse_pkg;

    // Symbol encoding inside a letter code, MSB is sent first
    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;

    // Element lengths in Morse time units
    localparam int DOT_UNITS  = 1;
    localparam int DASH_UNITS = 3;
    localparam int SGAP_UNITS = 1;
    localparam int LGAP_UNITS = 3;

    // Widest symbol count a letter can carry
    localparam logic [2:0] MAX_SYMBOLS = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        GAP,
        LGAP,
        DONE
    } morse_state_t;

    // Longer requests are truncated to the four symbols the code word holds
    function automatic logic [2:0] clampLen(input logic [2:0] lenIn);
        return (lenIn > MAX_SYMBOLS) ? MAX_SYMBOLS : lenIn;
    endfunction

endpackage

// File: rtl/morse_unit_tick.sv
// morse_unit_tick
// Prescaler that turns the system clock into Morse time-unit ticks.
// The count restarts whenever clr is high, so a new phase always
// begins with a full unit.
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   clr   in   restart the count from zero
//   tick  out  high for one cycle every UNIT_CYCLES cycles

module morse_unit_tick #(
    parameter int UNIT_CYCLES = 6750000,
    parameter int CNT_W       = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(UNIT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // tick is decoded from the count so it lines up with the cycle the
    // count wraps; the owner sees it in the same cycle it acts on it
    assign tick = (r_cnt == LAST);

    // Cycle counter runs 0..UNIT_CYCLES-1 and wraps; clr wins over wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/morse_tx.sv
// morse_tx
// Morse transmitter. Accepts one letter (up to four symbols, MSB
// first, 0=dot 1=dash) over a valid/ready handshake and plays it on
// an LED: dots of one unit, dashes of DASH_UNITS, one-unit gaps
// between symbols and an LGAP_UNITS gap after the letter, followed
// by a one-cycle done pulse.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   code[3:0] in   symbols, code[3] sent first
//   len[2:0]  in   number of symbols (values above 4 act as 4)
//   valid_in  in   letter offered
//   ready     out  idle and able to accept a letter
//   led       out  Morse output, 1 = mark
//   busy      out  letter in progress
//   done      out  one-cycle pulse at the end of the letter gap

module morse_tx #(
    parameter int UNIT_CYCLES = 6750000,
    parameter int DASH_UNITS  = morse_pkg::DASH_UNITS,
    parameter int LGAP_UNITS  = morse_pkg::LGAP_UNITS,
    parameter int CNT_W       = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] code,
    input  logic [2:0] len,
    input  logic       valid_in,
    output logic       ready,
    output logic       led,
    output logic       busy,
    output logic       done
);

    import morse_pkg::*;

    morse_state_t r_state;
    logic [3:0]   r_sr;
    logic [2:0]   r_symCnt;
    logic [7:0]   r_unitCnt;
    logic         r_led;
    logic         r_busy;
    logic         r_done;
    logic         r_ready;

    logic         w_tick;
    logic         w_clr;
    logic         w_accept;
    logic [2:0]   w_lenClamp;
    logic [7:0]   w_target;
    logic         w_timedState;
    logic         w_phaseEnd;

    assign ready = r_ready;
    assign led   = r_led;
    assign busy  = r_busy;
    assign done  = r_done;

    assign w_accept   = valid_in && r_ready;
    assign w_lenClamp = clampLen(len);

    // Length of the current phase in units; the mark length follows the
    // symbol sitting at the top of the shift register
    always_comb begin
        w_target = 8'(DOT_UNITS);
        case (r_state)
            MARK:    w_target = (r_sr[3] == SYM_DASH) ? 8'(DASH_UNITS) : 8'(DOT_UNITS);
            GAP:     w_target = 8'(SGAP_UNITS);
            LGAP:    w_target = 8'(LGAP_UNITS);
            default: w_target = 8'(DOT_UNITS);
        endcase
    end

    assign w_timedState = (r_state == MARK) || (r_state == GAP) || (r_state == LGAP);
    assign w_phaseEnd   = w_timedState && w_tick && (r_unitCnt == (w_target - 8'd1));

    // Counters are held at zero while untimed and cleared on every phase
    // change, so each phase starts from a clean full unit
    assign w_clr = !w_timedState || w_phaseEnd;

    morse_unit_tick #(
        .UNIT_CYCLES (UNIT_CYCLES),
        .CNT_W       (CNT_W)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .tick (w_tick)
    );

    // Unit counter: number of whole units already spent in this phase
    always_ff @(posedge clk) begin
        if (rst) begin
            r_unitCnt <= '0;
        end else if (w_clr) begin
            r_unitCnt <= '0;
        end else if (w_tick) begin
            r_unitCnt <= r_unitCnt + 8'd1;
        end
    end

    // Letter sequencer. All outputs are registered and change together
    // with the state, which is what makes led rise the cycle after the
    // accept and keeps every led interval a whole number of units
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_sr     <= '0;
            r_symCnt <= '0;
            r_led    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_sr     <= code;
                        r_symCnt <= w_lenClamp;
                        r_ready  <= 1'b0;
                        if (w_lenClamp == 3'd0) begin
                            // Empty letter: nothing to play, report at once
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= MARK;
                            r_led   <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                end

                MARK: begin
                    if (w_phaseEnd) begin
                        r_led    <= 1'b0;
                        r_sr     <= {r_sr[2:0], 1'b0};
                        r_symCnt <= r_symCnt - 3'd1;
                        r_state  <= (r_symCnt == 3'd1) ? LGAP : GAP;
                    end
                end

                GAP: begin
                    if (w_phaseEnd) begin
                        r_led   <= 1'b1;
                        r_state <= MARK;
                    end
                end

                LGAP: begin
                    if (w_phaseEnd) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end

                DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                    r_led   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_tx.sv
// tb_morse_tx
// Scoreboard bench for morse_tx with UNIT_CYCLES=4. Each letter issued
// pushes its expected led edges, done pulse and ready return (with the
// cycle they must be seen) into a queue; a monitor running on the
// falling edge pops and compares every event the DUT produces.

module tb_morse_tx;

    localparam int U = 4;

    // Event kinds seen by the monitor
    localparam int EV_RISE  = 0;
    localparam int EV_FALL  = 1;
    localparam int EV_DONE  = 2;
    localparam int EV_READY = 3;

    typedef struct {
        int kind;
        int at;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] code = 4'd0;
    logic [2:0] len = 3'd0;
    logic       valid_in = 1'b0;
    logic       ready;
    logic       led;
    logic       busy;
    logic       done;

    int  cyc = 0;
    ev_t expQ[$];
    int  nCompared = 0;
    int  nMismatched = 0;
    bit  monOn = 1'b0;
    logic prevLed;
    logic prevReady;

    morse_tx #(
        .UNIT_CYCLES (U),
        .DASH_UNITS  (3),
        .LGAP_UNITS  (3),
        .CNT_W       (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .code     (code),
        .len      (len),
        .valid_in (valid_in),
        .ready    (ready),
        .led      (led),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Cycle index: number of rising edges so far
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kindName(input int k);
        case (k)
            EV_RISE:  return "led_rise";
            EV_FALL:  return "led_fall";
            EV_DONE:  return "done";
            EV_READY: return "ready_rise";
            default:  return "unknown";
        endcase
    endfunction

    task automatic pushEv(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        expQ.push_back(e);
    endtask

    // Compare one observed event with the head of the scoreboard
    task automatic checkEvent(input int kind);
        ev_t e;
        nCompared++;
        if (expQ.size() == 0) begin
            nMismatched++;
            $display("[TB] FAIL event: got %s at cycle %0d, expected no event",
                     kindName(kind), cyc);
        end else begin
            e = expQ.pop_front();
            if (e.kind != kind || e.at != cyc) begin
                nMismatched++;
                $display("[TB] FAIL event: got %s at cycle %0d, expected %s at cycle %0d",
                         kindName(kind), cyc, kindName(e.kind), e.at);
            end
        end
    endtask

    // Direct level comparison
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: every led edge, done-high cycle and ready rise is an event
    always @(negedge clk) begin
        if (monOn) begin
            if (led !== prevLed) checkEvent((led === 1'b1) ? EV_RISE : EV_FALL);
            if (done === 1'b1) checkEvent(EV_DONE);
            if (ready === 1'b1 && prevReady !== 1'b1) checkEvent(EV_READY);
            prevLed   = led;
            prevReady = ready;
        end
    end

    // Offer a letter (entered and left on a falling edge). Once ready is
    // seen the accept edge follows; base is the cycle index observed just
    // before it, so "cycle k after accept" is observed at base+k.
    // expDone is the hand-computed done cycle; doModel=0 pushes nothing.
    task automatic applyStimulus(input logic [3:0] c, input logic [2:0] l,
                                 input int expDone, input bit hold,
                                 input bit doModel, output int base);
        int  t;
        int  n;
        int  mark;
        bit  got;
        code     = c;
        len      = l;
        valid_in = 1'b1;
        got      = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (ready === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL accept_timeout: got ready=%b, expected 1", ready);
        end
        base = cyc;
        if (doModel) begin
            n = (l > 3'd4) ? 4 : int'(l);
            t = base;
            for (int i = 0; i < n; i++) begin
                mark = c[3-i] ? 3 * U : U;
                pushEv(EV_RISE, t + 1);
                pushEv(EV_FALL, t + mark + 1);
                t = t + mark;
                if (i < n - 1) t = t + U;
            end
            pushEv(EV_DONE, base + expDone);
            pushEv(EV_READY, base + expDone + 1);
        end
        @(negedge clk);
        if (!hold) valid_in = 1'b0;
    endtask

    // Wait until the scoreboard drains and the DUT is idle again
    task automatic waitIdle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (expQ.size() == 0 && ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL idle_timeout: got %0d pending events, expected 0", expQ.size());
            expQ.delete();
        end
    endtask

    initial begin
        int b;
        int b1;
        int b2;
        ev_t e;

        // Reset held for three cycles
        repeat (3) @(negedge clk);
        checkOutput("reset_led", {31'd0, led}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_ready", {31'd0, ready}, 32'd1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("idle_led", {31'd0, led}, 32'd0);
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("idle_done", {31'd0, done}, 32'd0);
        checkOutput("idle_ready", {31'd0, ready}, 32'd1);
        prevLed   = led;
        prevReady = ready;
        monOn     = 1'b1;

        // Single dot: 1 + 3 units, done at cycle 17
        applyStimulus(4'b0000, 3'd1, 17, 1'b0, 1'b1, b);
        checkOutput("dot_busy", {31'd0, busy}, 32'd1);
        waitIdle();

        // Q = dash dash dot dash: 16 units, done at 65; stray valid mid-letter
        applyStimulus(4'b1101, 3'd4, 65, 1'b0, 1'b1, b);
        repeat (8) @(negedge clk);
        checkOutput("q_ready_mid", {31'd0, ready}, 32'd0);
        code     = 4'b0000;
        len      = 3'd1;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        waitIdle();

        // 0110 len 4: 8 + 3 + 3 = 14 units, done at 57
        applyStimulus(4'b0110, 3'd4, 57, 1'b0, 1'b1, b);
        waitIdle();

        // len 0: no marks, done one cycle after accept
        applyStimulus(4'b1111, 3'd0, 1, 1'b0, 1'b1, b);
        waitIdle();

        // len 7 behaves as len 4
        applyStimulus(4'b0110, 3'd7, 57, 1'b0, 1'b1, b);
        waitIdle();

        // Reset during a dash: led drops and ready returns, no done
        applyStimulus(4'b1000, 3'd1, 0, 1'b0, 1'b0, b);
        pushEv(EV_RISE, b + 1);
        pushEv(EV_FALL, b + 7);
        pushEv(EV_READY, b + 7);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("abort_no_done", {31'd0, done}, 32'd0);
        waitIdle();
        applyStimulus(4'b0000, 3'd1, 17, 1'b0, 1'b1, b);
        waitIdle();

        // Back-to-back E then T with valid held high
        applyStimulus(4'b0000, 3'd1, 17, 1'b1, 1'b1, b1);
        applyStimulus(4'b1000, 3'd1, 25, 1'b0, 1'b1, b2);
        checkOutput("b2b_accept_spacing", b2 - b1, 32'd18);
        waitIdle();

        repeat (4) @(negedge clk);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL missing_event: got nothing, expected %s at cycle %0d",
                     kindName(e.kind), e.at);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    // Global guard so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 200000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
